// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshakes, tag pass-through and an iterative
// shift-add multiplier / restoring divider that retires one bit per cycle.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [3:0]       alu_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SLTU  = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [3:0]         op_q;
  logic [TAG_W-1:0]   tag_q;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quot;

  logic               accept;
  logic               is_mul;
  logic               is_div;
  logic               is_iter;
  logic               is_dbz;
  logic               is_illegal;
  logic [WIDTH-1:0]   single_res;
  logic               single_ov;
  logic [WIDTH-1:0]   add_sum;
  logic [WIDTH-1:0]   sub_diff;
  logic [SH_W-1:0]    sh;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH:0]     div_tmp;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quot_step;
  logic [WIDTH-1:0]   iter_res;

  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Request acceptance depends on state; DONE can hand off and accept in one edge
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Request classification
  always_comb begin
    is_mul     = (alu_op == OP_MUL) || (alu_op == OP_MULHU);
    is_div     = (alu_op == OP_DIVU) || (alu_op == OP_REMU);
    is_dbz     = is_div && (operand_b == {WIDTH{1'b0}});
    is_iter    = is_mul || (is_div && !is_dbz);
    is_illegal = (alu_op == 4'b1110) || (alu_op == 4'b1111);
  end

  // Single-cycle result and signed overflow straight from the request operands
  always_comb begin
    add_sum    = operand_a + operand_b;
    sub_diff   = operand_a - operand_b;
    sh         = operand_b[SH_W-1:0];
    single_res = {WIDTH{1'b0}};
    single_ov  = 1'b0;
    case (alu_op)
      OP_ADD: begin
        single_res = add_sum;
        single_ov  = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                     (add_sum[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        single_res = sub_diff;
        single_ov  = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                     (sub_diff[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_AND:  single_res = operand_a & operand_b;
      OP_OR:   single_res = operand_a | operand_b;
      OP_XOR:  single_res = operand_a ^ operand_b;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
      OP_SLL:  single_res = operand_a << sh;
      OP_SRL:  single_res = operand_a >> sh;
      OP_SRA:  single_res = $unsigned($signed(operand_a) >>> sh);
      OP_DIVU: single_res = {WIDTH{1'b1}};
      OP_REMU: single_res = operand_a;
      default: single_res = {WIDTH{1'b0}};
    endcase
  end

  // One multiply / divide iteration; the final iteration's outputs feed the result
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                (prod[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    prod_step = {mul_sum, prod[WIDTH-1:1]};
    div_tmp   = {rem, quot[WIDTH-1]};
    div_diff  = div_tmp - {1'b0, b_q};
    if (!div_diff[WIDTH]) begin
      rem_step  = div_diff[WIDTH-1:0];
      quot_step = {quot[WIDTH-2:0], 1'b1};
    end else begin
      rem_step  = div_tmp[WIDTH-1:0];
      quot_step = {quot[WIDTH-2:0], 1'b0};
    end
    case (op_q)
      OP_MUL:   iter_res = prod_step[WIDTH-1:0];
      OP_MULHU: iter_res = prod_step[2*WIDTH-1:WIDTH];
      OP_DIVU:  iter_res = quot_step;
      OP_REMU:  iter_res = rem_step;
      default:  iter_res = {WIDTH{1'b0}};
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = is_iter ? BUSY : DONE;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        if (count == CNT_W'(1)) begin
          state_next = DONE;
        end else begin
          state_next = BUSY;
        end
      end
      DONE: begin
        if (accept) begin
          state_next = is_iter ? BUSY : DONE;
        end else if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, iteration registers and registered result/flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      op_q        <= 4'b0000;
      tag_q       <= {TAG_W{1'b0}};
      count       <= {CNT_W{1'b0}};
      prod        <= {(2*WIDTH){1'b0}};
      rem         <= {WIDTH{1'b0}};
      quot        <= {WIDTH{1'b0}};
      result      <= {WIDTH{1'b0}};
      out_tag     <= {TAG_W{1'b0}};
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else if (accept) begin
      a_q   <= operand_a;
      b_q   <= operand_b;
      op_q  <= alu_op;
      tag_q <= in_tag;
      count <= CNT_W'(WIDTH);
      prod  <= {{WIDTH{1'b0}}, operand_b};
      rem   <= {WIDTH{1'b0}};
      quot  <= operand_a;
      if (is_iter) begin
        result      <= {WIDTH{1'b0}};
        out_tag     <= {TAG_W{1'b0}};
        zero        <= 1'b0;
        overflow    <= 1'b0;
        div_by_zero <= 1'b0;
        illegal_op  <= 1'b0;
      end else begin
        result      <= single_res;
        out_tag     <= in_tag;
        zero        <= (single_res == {WIDTH{1'b0}});
        overflow    <= single_ov;
        div_by_zero <= is_dbz;
        illegal_op  <= is_illegal;
      end
    end else if (state == BUSY) begin
      count <= count - CNT_W'(1);
      prod  <= prod_step;
      rem   <= rem_step;
      quot  <= quot_step;
      if (count == CNT_W'(1)) begin
        result  <= iter_res;
        out_tag <= tag_q;
        zero    <= (iter_res == {WIDTH{1'b0}});
      end
    end else if ((state == DONE) && out_ready) begin
      result      <= {WIDTH{1'b0}};
      out_tag     <= {TAG_W{1'b0}};
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at WIDTH=32: single-cycle ops,
// iterative mul/div latency, divide by zero, backpressure, back-to-back and mid-op reset.
module tb_alu_multicycle;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  alu_op;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  out_tag;
  logic        zero;
  logic        overflow;
  logic        div_by_zero;
  logic        illegal_op;

  int pass_cnt;
  int check_cnt;

  alu_multicycle #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b), .alu_op(alu_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag),
    .zero(zero), .overflow(overflow), .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for out_valid; lat counts the request cycle as 1.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output int lat, output logic ready_seen);
    @(negedge clk);
    alu_op = op; operand_a = a; operand_b = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    operand_a = 32'hDEAD_BEEF;
    operand_b = 32'h0000_0003;
    lat = 1;
    ready_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      ready_seen = ready_seen | in_ready;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 4'b0000; operand_a = 32'h0; operand_b = 32'h0; in_tag = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check_cnt++;
    if ({out_valid, result, out_tag, zero, overflow, div_by_zero, illegal_op} !== 42'd0)
      $display("FAIL reset_outputs: got valid=%b result=%h tag=%h flags=%b%b%b%b, want all 0",
               out_valid, result, out_tag, zero, overflow, div_by_zero, illegal_op);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_add();
    int lat; logic rs;
    run_op(4'b0000, 32'd10, 32'd15, 5'd3, lat, rs);
    check_cnt++;
    if ({result, zero, overflow, out_tag} !== {32'd25, 1'b0, 1'b0, 5'd3})
      $display("FAIL add_basic: got result=%0d zero=%b ovf=%b tag=%0d want 25/0/0/3",
               result, zero, overflow, out_tag);
    else pass_cnt++;
    check_cnt++;
    if (lat !== 1) $display("FAIL add_latency: got %0d want 1", lat);
    else pass_cnt++;
    run_op(4'b0000, 32'h7FFF_FFFF, 32'd1, 5'd4, lat, rs);
    check_cnt++;
    if ({result, overflow} !== {32'h8000_0000, 1'b1})
      $display("FAIL add_overflow: got result=%h ovf=%b want 80000000/1", result, overflow);
    else pass_cnt++;
  endtask

  task automatic test_compare_shift();
    int lat; logic rs;
    run_op(4'b0101, 32'hFFFF_FFFF, 32'd1, 5'd5, lat, rs);
    check_cnt++;
    if (result !== 32'd1) $display("FAIL slt: got %h want 1", result);
    else pass_cnt++;
    run_op(4'b0110, 32'hFFFF_FFFF, 32'd1, 5'd6, lat, rs);
    check_cnt++;
    if (result !== 32'd0) $display("FAIL sltu: got %h want 0", result);
    else pass_cnt++;
    run_op(4'b1001, 32'h8000_0000, 32'h0000_0021, 5'd7, lat, rs);
    check_cnt++;
    if (result !== 32'hC000_0000) $display("FAIL sra: got %h want c0000000", result);
    else pass_cnt++;
    run_op(4'b0111, 32'h0000_00F1, 32'h0000_0104, 5'd8, lat, rs);
    check_cnt++;
    if (result !== 32'h0000_0F10) $display("FAIL sll: got %h want 00000f10", result);
    else pass_cnt++;
  endtask

  task automatic test_mul();
    int lat; logic rs;
    run_op(4'b1010, 32'h0001_0000, 32'h0001_0000, 5'd10, lat, rs);
    check_cnt++;
    if ({result, zero, out_tag} !== {32'd0, 1'b1, 5'd10})
      $display("FAIL mul_low: got result=%h zero=%b tag=%0d want 0/1/10", result, zero, out_tag);
    else pass_cnt++;
    check_cnt++;
    if (lat !== 33) $display("FAIL mul_latency: got %0d want 33", lat);
    else pass_cnt++;
    check_cnt++;
    if (rs !== 1'b0) $display("FAIL mul_busy_ready: got in_ready seen=%b want 0", rs);
    else pass_cnt++;
    run_op(4'b1011, 32'h0001_0000, 32'h0001_0000, 5'd11, lat, rs);
    check_cnt++;
    if (result !== 32'd1) $display("FAIL mulhu: got %h want 1", result);
    else pass_cnt++;
    run_op(4'b1010, 32'd1234, 32'd5678, 5'd12, lat, rs);
    check_cnt++;
    if (result !== 32'd7006652) $display("FAIL mul_small: got %0d want 7006652", result);
    else pass_cnt++;
  endtask

  task automatic test_div();
    int lat; logic rs;
    run_op(4'b1100, 32'd100, 32'd7, 5'd13, lat, rs);
    check_cnt++;
    if ({result, div_by_zero} !== {32'd14, 1'b0})
      $display("FAIL divu: got result=%0d dbz=%b want 14/0", result, div_by_zero);
    else pass_cnt++;
    check_cnt++;
    if (lat !== 33) $display("FAIL divu_latency: got %0d want 33", lat);
    else pass_cnt++;
    run_op(4'b1101, 32'd100, 32'd7, 5'd14, lat, rs);
    check_cnt++;
    if (result !== 32'd2) $display("FAIL remu: got %0d want 2", result);
    else pass_cnt++;
    run_op(4'b1100, 32'd5, 32'd0, 5'd15, lat, rs);
    check_cnt++;
    if ({result, div_by_zero, lat} !== {32'hFFFF_FFFF, 1'b1, 32'd1})
      $display("FAIL divu_by_zero: got result=%h dbz=%b lat=%0d want ffffffff/1/1",
               result, div_by_zero, lat);
    else pass_cnt++;
    run_op(4'b1101, 32'd5, 32'd0, 5'd16, lat, rs);
    check_cnt++;
    if ({result, div_by_zero} !== {32'd5, 1'b1})
      $display("FAIL remu_by_zero: got result=%h dbz=%b want 5/1", result, div_by_zero);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    int lat; logic rs;
    run_op(4'b1110, 32'd9, 32'd9, 5'd17, lat, rs);
    check_cnt++;
    if ({result, zero, illegal_op, overflow, div_by_zero} !== {32'd0, 1'b1, 1'b1, 1'b0, 1'b0})
      $display("FAIL illegal: got result=%h zero=%b ill=%b ovf=%b dbz=%b want 0/1/1/0/0",
               result, zero, illegal_op, overflow, div_by_zero);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int lat; logic rs; int bad;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    run_op(4'b0001, 32'd5, 32'd5, 5'd18, lat, rs);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if ({out_valid, result, zero, in_ready, out_tag} !== {1'b1, 32'd0, 1'b1, 1'b0, 5'd18}) bad++;
      @(posedge clk);
      #1;
    end
    check_cnt++;
    if (bad !== 0)
      $display("FAIL backpressure_hold: %0d bad cycles, last valid=%b result=%h zero=%b rdy=%b want 1/0/1/0",
               bad, out_valid, result, zero, in_ready);
    else pass_cnt++;
    @(negedge clk);
    out_ready = 1'b1;
    alu_op = 4'b0100; operand_a = 32'h0000_F0F0; operand_b = 32'h0000_0FF0;
    in_tag = 5'd9; in_valid = 1'b1;
    #1;
    check_cnt++;
    if (in_ready !== 1'b1) $display("FAIL handoff_ready: got %b want 1", in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_cnt++;
    if ({out_valid, result, out_tag, zero} !== {1'b1, 32'h0000_FF00, 5'd9, 1'b0})
      $display("FAIL handoff_xor: got valid=%b result=%h tag=%0d zero=%b want 1/0000ff00/9/0",
               out_valid, result, out_tag, zero);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      alu_op = 4'b0000; operand_a = 32'(i + 1); operand_b = 32'd100;
      in_tag = 5'(i + 20); in_valid = 1'b1;
      @(posedge clk);
      #1;
      if ({out_valid, result, out_tag} !== {1'b1, 32'(i + 101), 5'(i + 20)}) bad++;
    end
    in_valid = 1'b0;
    check_cnt++;
    if (bad !== 0)
      $display("FAIL back_to_back: %0d bad results, last valid=%b result=%0d tag=%0d",
               bad, out_valid, result, out_tag);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_busy();
    int lat; logic rs; int stale;
    @(negedge clk);
    alu_op = 4'b1100; operand_a = 32'd1000; operand_b = 32'd3; in_tag = 5'd25; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_cnt++;
    if ({out_valid, result, out_tag, zero, overflow, div_by_zero, illegal_op} !== 42'd0)
      $display("FAIL mid_reset_outputs: got valid=%b result=%h tag=%h, want all 0",
               out_valid, result, out_tag);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) stale++;
    end
    check_cnt++;
    if (stale !== 0) $display("FAIL mid_reset_stale: got %0d valid cycles want 0", stale);
    else pass_cnt++;
    run_op(4'b0000, 32'd1, 32'd1, 5'd26, lat, rs);
    check_cnt++;
    if ({result, lat, out_tag} !== {32'd2, 32'd1, 5'd26})
      $display("FAIL post_reset_add: got result=%0d lat=%0d tag=%0d want 2/1/26", result, lat, out_tag);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    check_cnt = 0;
    test_reset();
    test_add();
    test_compare_shift();
    test_mul();
    test_div();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
